// File: rtl/core_mul_unit.sv
// Radix-4 iterative multiplier with writeback handshake.
// Two multiplier bits per cycle; result is the low WIDTH bits.
module core_mul_unit #(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 16,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [RW-1:0]    op_rd,
  input  logic             flush,
  input  logic             wb_ready,
  output logic             busy,
  output logic             wb_valid,
  output logic [RW-1:0]    wb_rd,
  output logic [WIDTH-1:0] wb_value,
  output logic [NREGS-1:0] raw_mask
);

  localparam int STEPS = WIDTH / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] partial;
  logic [RW-1:0]    rd_q;
  logic             load;

  assign load = start && !flush && !busy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (load) state_n = RUN;
      RUN: begin
        if (flush)            state_n = IDLE;
        else if (cnt == LAST) state_n = DONE;
      end
      DONE: begin
        if (flush)         state_n = IDLE;
        else if (wb_ready) state_n = load ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN) ||
               ((state == DONE) && !wb_ready);
    wb_valid = (state == DONE);
    wb_value = wb_valid ? acc : '0;
    wb_rd    = wb_valid ? rd_q : '0;
    raw_mask = (state != IDLE) ?
               (NREGS'(1) << rd_q) : '0;
  end

  // 3x is built as x + 2x so no multiplier is inferred
  always_comb begin
    partial = '0;
    unique case (mplier[1:0])
      2'd0: partial = '0;
      2'd1: partial = mcand;
      2'd2: partial = mcand << 1;
      2'd3: partial = mcand + (mcand << 1);
      default: partial = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rd_q   <= '0;
    end else if (load) begin
      acc    <= '0;
      cnt    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      rd_q   <= op_rd;
    end else if (state == RUN) begin
      if (flush) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc    <= acc + partial;
        cnt    <= cnt + CW'(1);
        mcand  <= mcand << 2;
        mplier <= mplier >> 2;
      end
    end
  end

endmodule

// File: tb/tb_core_mul_unit.sv
// Directed bench for core_mul_unit.
// Cycle c begins 2ns after a rising edge.
module tb_core_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  op_rd;
  logic        flush;
  logic        wb_ready;
  logic        busy;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_value;
  logic [15:0] raw_mask;

  int checks = 0;
  int errors = 0;

  core_mul_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_rd    (op_rd),
    .flush    (flush),
    .wb_ready (wb_ready),
    .busy     (busy),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_value (wb_value),
    .raw_mask (raw_mask)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [3:0] rd,
                        input logic [31:0] exp);
    int lat;
    op_a = a; op_b = b; op_rd = rd;
    wb_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    while (wb_valid !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd17);
    chk({tag, " value"}, wb_value, exp);
    chk({tag, " rd"}, wb_rd, rd);
    tick;
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle mask"}, raw_mask, 0);
  endtask

  initial begin
    int c;
    int nvalid;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    wb_ready = 1'b1;
    op_a = '0; op_b = '0; op_rd = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst valid", wb_valid, 0);
    chk("rst value", wb_value, 0);
    chk("rst rd", wb_rd, 0);
    chk("rst mask", raw_mask, 0);

    // 7*6 into r3, full cycle-by-cycle trace
    op_a = 32'd7; op_b = 32'd6; op_rd = 4'd3;
    start = 1'b1;
    #1;
    chk("c0 busy", busy, 0);
    chk("c0 mask", raw_mask, 0);
    tick;
    start = 1'b0;
    op_a = 32'd1000; op_b = 32'd1000;
    for (c = 1; c <= 17; c++) begin
      chk($sformatf("mask c%0d", c), raw_mask, 16'h0008);
      chk($sformatf("valid c%0d", c), wb_valid, c == 17);
      chk($sformatf("busy c%0d", c), busy, c != 17);
      chk($sformatf("value c%0d", c), wb_value,
          (c == 17) ? 42 : 0);
      chk($sformatf("rd c%0d", c), wb_rd,
          (c == 17) ? 3 : 0);
      tick;
    end
    chk("c18 busy", busy, 0);
    chk("c18 mask", raw_mask, 0);
    chk("c18 valid", wb_valid, 0);

    run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           4'd1, 32'h0000_0001);
    run_op("msb", 32'h8000_0000, 32'd2,
           4'd2, 32'h0000_0000);
    run_op("mix", 32'd12345, 32'd678,
           4'd15, 32'h007F_B6F6);
    run_op("dig3", 32'd3, 32'd15,
           4'd0, 32'd45);
    run_op("zero", 32'hDEAD_BEEF, 32'd0,
           4'd9, 32'd0);

    // backpressure, plus starts that must be ignored
    op_a = 32'd9; op_b = 32'd11; op_rd = 4'd5;
    start = 1'b1;
    tick;
    wb_ready = 1'b0;
    for (c = 1; c <= 16; c++) begin
      start = (c == 5);
      op_a = 32'd100; op_b = 32'd100; op_rd = 4'd9;
      tick;
    end
    for (c = 17; c <= 21; c++) begin
      start = (c >= 18 && c <= 20);
      #1;
      chk($sformatf("bp valid c%0d", c), wb_valid, 1);
      chk($sformatf("bp value c%0d", c), wb_value, 99);
      chk($sformatf("bp rd c%0d", c), wb_rd, 5);
      chk($sformatf("bp busy c%0d", c), busy, 1);
      tick;
    end
    start = 1'b0;
    wb_ready = 1'b1;
    #1;
    chk("bp c22 valid", wb_valid, 1);
    chk("bp c22 value", wb_value, 99);
    chk("bp c22 busy", busy, 0);
    tick;
    chk("bp c23 valid", wb_valid, 0);
    chk("bp c23 mask", raw_mask, 0);
    chk("bp c23 busy", busy, 0);

    // flush during RUN
    op_a = 32'd3; op_b = 32'd3; op_rd = 4'd7;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (c = 1; c < 8; c++) tick;
    chk("fl c8 mask", raw_mask, 16'h0080);
    chk("fl c8 busy", busy, 1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fl c9 mask", raw_mask, 0);
    chk("fl c9 busy", busy, 0);
    nvalid = 0;
    for (c = 9; c < 30; c++) begin
      if (wb_valid === 1'b1) nvalid++;
      tick;
    end
    chk("fl no valid", 64'(nvalid), 0);

    // flush in DONE without ready drops the result
    op_a = 32'd6; op_b = 32'd6; op_rd = 4'd8;
    start = 1'b1;
    tick;
    start = 1'b0;
    wb_ready = 1'b0;
    for (c = 1; c < 17; c++) tick;
    chk("fd0 valid", wb_valid, 1);
    chk("fd0 value", wb_value, 36);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fd0 drop valid", wb_valid, 0);
    chk("fd0 drop mask", raw_mask, 0);
    chk("fd0 drop busy", busy, 0);
    wb_ready = 1'b1;

    // flush in DONE with ready, start blocked by flush
    op_a = 32'd8; op_b = 32'd8; op_rd = 4'd6;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (c = 1; c < 17; c++) tick;
    flush = 1'b1; start = 1'b1;
    #1;
    chk("fd1 valid", wb_valid, 1);
    chk("fd1 value", wb_value, 64);
    chk("fd1 busy", busy, 0);
    tick;
    chk("fd1 after mask", raw_mask, 0);
    chk("fd1 after busy", busy, 0);
    tick;
    flush = 1'b0; start = 1'b0;
    chk("fl idle start mask", raw_mask, 0);
    chk("fl idle start busy", busy, 0);

    // back-to-back issue on the handshake cycle
    op_a = 32'd4; op_b = 32'd4; op_rd = 4'd1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (c = 1; c < 17; c++) tick;
    op_a = 32'd5; op_b = 32'd5; op_rd = 4'd2;
    start = 1'b1;
    #1;
    chk("b2b c17 valid", wb_valid, 1);
    chk("b2b c17 value", wb_value, 16);
    chk("b2b c17 rd", wb_rd, 1);
    tick;
    start = 1'b0;
    chk("b2b c18 busy", busy, 1);
    chk("b2b c18 mask", raw_mask, 16'h0004);
    nvalid = 0;
    for (c = 18; c < 34; c++) begin
      if (wb_valid === 1'b1) nvalid++;
      tick;
    end
    chk("b2b early valid", 64'(nvalid), 0);
    chk("b2b c34 valid", wb_valid, 1);
    chk("b2b c34 value", wb_value, 25);
    chk("b2b c34 rd", wb_rd, 2);
    tick;

    // reset wins over start and flush mid-run
    op_a = 32'd13; op_b = 32'd17; op_rd = 4'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (c = 1; c < 10; c++) tick;
    rst = 1'b1; start = 1'b1; flush = 1'b1;
    wb_ready = 1'b0;
    tick;
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    wb_ready = 1'b1;
    chk("mr valid", wb_valid, 0);
    chk("mr value", wb_value, 0);
    chk("mr rd", wb_rd, 0);
    chk("mr mask", raw_mask, 0);
    chk("mr busy", busy, 0);
    tick;
    chk("mr idle busy", busy, 0);
    run_op("post rst", 32'd13, 32'd17, 4'd4, 32'd221);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
